// File: rtl/inst_fetch_bridge.sv
// Instruction fetch bridge: turns PC-stage fetch addresses into req/gnt/rvalid
// bus reads, returns the word to IF/ID and stalls the pipeline until it is ready.
module inst_fetch_bridge #(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_i,
   input  logic              ce_i,
   input  logic              flush,
   input  logic [5:0]        stall,
   output logic [DATA_W-1:0] inst_o,
   output logic              stallreq_o,
   output logic              bus_err_o,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic              mem_gnt_i,
   input  logic              mem_rvalid_i,
   input  logic [DATA_W-1:0] mem_rdata_i
);

   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] inst_q, inst_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              discard_q, discard_d;
   logic              mem_req_q, mem_req_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              bus_err_q, bus_err_d;

   logic [ADDR_W-1:0] pc_aligned;
   logic              hit_c;
   logic              unused_stall;

   // The PC-held bit only matters through pc_i staying put; the rest of the vector is not used here.
   assign unused_stall = ^stall;

   // Word-aligned bus address; the low two pc bits never reach the bus.
   assign pc_aligned = {pc_i[ADDR_W-1:2], 2'b00};

   // The word for the current pc is sitting in inst_q.
   assign hit_c = (state_q == S_DONE) && (addr_q == pc_i);

   // Combinational outputs toward IF/ID and the control unit.
   assign inst_o     = (state_q == S_DONE) ? inst_q : '0;
   assign stallreq_o = rst & ce_i & ~flush & ~hit_c;

   assign mem_req_o  = mem_req_q;
   assign mem_addr_o = mem_addr_q;
   assign bus_err_o  = bus_err_q;

   // Next-state and datapath updates for the fetch FSM.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      inst_d     = inst_q;
      cnt_d      = cnt_q;
      discard_d  = discard_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      bus_err_d  = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            mem_req_d = 1'b0;
            if (ce_i && !flush) begin
               addr_d     = pc_i;
               mem_addr_d = pc_aligned;
               mem_req_d  = 1'b1;
               state_d    = S_REQ;
            end
         end

         S_REQ: begin
            // The request stays up until granted; a flush only marks the result for dropping.
            if (flush) begin
               discard_d = 1'b1;
            end
            if (mem_gnt_i) begin
               mem_req_d = 1'b0;
               cnt_d     = '0;
               state_d   = S_WAIT;
            end
         end

         S_WAIT: begin
            if (mem_rvalid_i) begin
               if (discard_q || flush) begin
                  discard_d = 1'b0;
                  state_d   = S_IDLE;
               end else begin
                  inst_d  = mem_rdata_i;
                  state_d = S_DONE;
               end
            end else if (cnt_q == CNT_LAST) begin
               // Abandon the fetch: deliver a nop and flag the bus error once.
               inst_d    = '0;
               bus_err_d = 1'b1;
               if (discard_q || flush) begin
                  discard_d = 1'b0;
                  state_d   = S_IDLE;
               end else begin
                  state_d = S_DONE;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               if (flush) begin
                  discard_d = 1'b1;
               end
            end
         end

         S_DONE: begin
            if (flush || !ce_i) begin
               state_d = S_IDLE;
            end else if (pc_i != addr_q) begin
               addr_d     = pc_i;
               mem_addr_d = pc_aligned;
               mem_req_d  = 1'b1;
               state_d    = S_REQ;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         inst_q     <= '0;
         cnt_q      <= '0;
         discard_q  <= 1'b0;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
         bus_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         inst_q     <= inst_d;
         cnt_q      <= cnt_d;
         discard_q  <= discard_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
         bus_err_q  <= bus_err_d;
      end
   end

endmodule
